// File: rtl/divider_pkg.sv
// Shared widths, iteration count and FSM encoding for the restoring divider.
package divider_pkg;

  localparam int unsigned DIV_W      = 32;
  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, emit one quotient bit.
module divider_step
  import divider_pkg::*;
(
  input  logic [DIV_W-1:0] i_remainder,
  input  logic [DIV_W-1:0] i_quotient,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W-1:0] o_remainder_c,
  output logic [DIV_W-1:0] o_quotient_c
);

  logic [DIV_W:0]   w_trial;
  logic [DIV_W-1:0] w_diff;
  logic             w_bit;

  // Trial value is 33 bits so divisors above 2^31 compare correctly.
  always_comb begin
    w_trial       = {i_remainder, i_quotient[DIV_W-1]};
    w_bit         = (w_trial >= {1'b0, i_divisor});
    w_diff        = DIV_W'(w_trial - {1'b0, i_divisor});
    o_remainder_c = w_bit ? w_diff : w_trial[DIV_W-1:0];
    o_quotient_c  = {i_quotient[DIV_W-2:0], w_bit};
  end

endmodule

// File: rtl/divider.sv
// 32-bit unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_DEBUG_EN to expose internal state on the debug_* ports (tied to 0 otherwise).
module divider
  import divider_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready_i,
  input  logic [DIV_W-1:0]     dividend_i,
  input  logic [DIV_W-1:0]     divisor_i,
  output logic                 valid_o,
  output logic [DIV_W-1:0]     quotient_o,
  output logic [DIV_W-1:0]     remainder_o,
  output logic [1:0]           debug_state,
  output logic [2*DIV_W-2:0]   debug_shift_reg,
  output logic [DIV_W-1:0]     debug_divisor
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_start;
  logic             w_calc;
  logic             w_finish;

  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W-1:0] r_quot_work;
  logic [DIV_W-1:0] r_rem_work;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic [DIV_W-1:0] r_quotient;
  logic [DIV_W-1:0] r_remainder;
  logic [DIV_W-1:0] w_rem_next;
  logic [DIV_W-1:0] w_quot_next;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (ready_i) w_next_state = ST_CALC;
      ST_CALC: if (r_count == LAST_CNT) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath control decoded from the current state
  always_comb begin
    w_start  = 1'b0;
    w_calc   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: w_start = ready_i;
      ST_CALC: begin
        w_calc   = 1'b1;
        w_finish = (r_count == LAST_CNT);
      end
      default: ;
    endcase
  end

  divider_step u_step (
    .i_remainder   (r_rem_work),
    .i_quotient    (r_quot_work),
    .i_divisor     (r_divisor),
    .o_remainder_c (w_rem_next),
    .o_quotient_c  (w_quot_next)
  );

  // Work registers, counter and result registers; results load on the final CALC edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divisor   <= '0;
      r_quot_work <= '0;
      r_rem_work  <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_valid <= w_finish;
      if (w_start) begin
        r_divisor   <= divisor_i;
        r_quot_work <= dividend_i;
        r_rem_work  <= '0;
        r_count     <= '0;
      end else if (w_calc) begin
        r_quot_work <= w_quot_next;
        r_rem_work  <= w_rem_next;
        r_count     <= r_count + CNT_W'(1);
      end
      if (w_finish) begin
        r_quotient  <= w_quot_next;
        r_remainder <= w_rem_next;
      end
    end
  end

  assign valid_o     = r_valid;
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;

`ifdef DIVIDER_DEBUG_EN
  assign debug_state     = r_state;
  assign debug_shift_reg = {r_rem_work[DIV_W-2:0], r_quot_work};
  assign debug_divisor   = r_divisor;
`else
  assign debug_state     = 2'd0;
  assign debug_shift_reg = '0;
  assign debug_divisor   = '0;
`endif

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider against a reference / and % scoreboard.
module tb_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } result_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        valid_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic [1:0]  debug_state;
  logic [62:0] debug_shift_reg;
  logic [31:0] debug_divisor;

  result_t     sb[$];
  int          m_cnt;
  logic [31:0] model_q;
  logic [31:0] model_r;
  int          n_checks;
  int          n_fail;

  divider dut (
    .clk             (clk),
    .reset           (reset),
    .ready_i         (ready_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .valid_o         (valid_o),
    .quotient_o      (quotient_o),
    .remainder_o     (remainder_o),
    .debug_state     (debug_state),
    .debug_shift_reg (debug_shift_reg),
    .debug_divisor   (debug_divisor)
  );

  always #5 clk = ~clk;

  function automatic result_t ref_div(input logic [31:0] a, input logic [31:0] b);
    result_t res;
    if (b == 32'd0) begin
      res.q = 32'hFFFF_FFFF;
      res.r = a;
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, model the start decision, check outputs #1 after posedge
  task automatic cycle(input logic rdy, input logic [31:0] a, input logic [31:0] b);
    bit      start;
    result_t e;
    @(negedge clk);
    ready_i    = rdy;
    dividend_i = a;
    divisor_i  = b;
    start      = rdy && (m_cnt == 0);
    if (start) sb.push_back(ref_div(a, b));
    @(posedge clk);
    #1;
    m_cnt      = start ? 33 : ((m_cnt == 0) ? 0 : m_cnt - 1);
    dividend_i = $urandom;
    divisor_i  = $urandom;
    chk("valid", 64'(valid_o), 64'(m_cnt == 1));
    if (m_cnt == 1) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        e       = sb.pop_front();
        model_q = e.q;
        model_r = e.r;
      end
    end
    chk("quotient", 64'(quotient_o), 64'(model_q));
    chk("remainder", 64'(remainder_o), 64'(model_r));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    cycle(1'b1, a, b);
    for (int i = 0; i < 33; i++) cycle(1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] pick_divisor();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 16));
      2:       return $urandom | 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    m_cnt      = 0;
    model_q    = '0;
    model_r    = '0;
    reset      = 1'b0;
    ready_i    = 1'b1;
    dividend_i = 32'd55;
    divisor_i  = 32'd3;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_quotient", 64'(quotient_o), 64'd0);
    chk("rst_remainder", 64'(remainder_o), 64'd0);
    chk("rst_debug_state", 64'(debug_state), 64'd0);
    chk("rst_debug_shift", 64'(debug_shift_reg), 64'd0);
    chk("rst_debug_divisor", 64'(debug_divisor), 64'd0);

    // Release with ready high: the very next edge starts 100/7
    #2 reset = 1'b0;
    run_op(32'd100, 32'd7);
    run_op(32'hFFFF_FFFF, 32'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd5, 32'd0);
    run_op(32'd0, 32'd5);
    run_op(32'd7, 32'd7);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF);

    // Back-to-back with ready held high and operands changing every half cycle
    for (int i = 0; i < 34 * 10; i++) cycle(1'b1, $urandom, pick_divisor());

    for (int i = 0; i < 40 && m_cnt != 0; i++) cycle(1'b0, $urandom, $urandom);
    chk("drained_idle", 64'(m_cnt), 64'd0);

    // Abort mid-calculation, after 10 CALC cycles
    cycle(1'b1, 32'd123456, 32'd789);
    for (int i = 0; i < 10; i++) cycle(1'b0, $urandom, $urandom);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_quotient", 64'(quotient_o), 64'd0);
    chk("abort_remainder", 64'(remainder_o), 64'd0);
    chk("abort_debug_state", 64'(debug_state), 64'd0);
    sb.delete();
    m_cnt   = 0;
    model_q = '0;
    model_r = '0;
    @(negedge clk);
    ready_i = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 40; i++) cycle(1'b0, $urandom, $urandom);
    run_op(32'd1000, 32'd3);
    run_op(32'hDEAD_BEEF, 32'h0001_0000);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits (DIV_W = 32, from package).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ready_i  in  1  start request; operands sampled on a rising edge in IDLE when high.
REQ-005 dividend_i  in  32  unsigned dividend.
REQ-006 divisor_i  in  32  unsigned divisor.
REQ-007 valid_o  out  1  result valid; high only in DONE.
REQ-008 quotient_o  out  32  unsigned quotient register.
REQ-009 remainder_o  out  32  unsigned remainder register.
REQ-010 debug_state  out  2  current FSM state encoding.
REQ-011 debug_shift_reg  out  63  {remainder_work[30:0], quotient_work[31:0]}.
REQ-012 debug_divisor  out  32  latched divisor.

Function
REQ-013 The block SHALL perform unsigned restoring division, one quotient bit per clock, MSB first.
REQ-014 The FSM SHALL have states IDLE=2'd0, CALC=2'd1, DONE=2'd2; 2'd3 is unused and SHALL return to IDLE on the next edge.
REQ-015 IDLE with ready_i=1: latch divisor; set quotient_work = dividend_i and remainder_work = 0; clear the 5-bit iteration counter; go to CALC.
REQ-016 IDLE with ready_i=0: hold all registers.
REQ-017 Each CALC cycle: t = {remainder_work, quotient_work[31]} (33 bits); if t >= divisor, remainder_work = t - divisor and the shifted-in quotient bit = 1; otherwise remainder_work = t[31:0] and the bit = 0; quotient_work shifts left with the new bit at bit 0.
REQ-018 After the 32nd CALC cycle (counter = 31), the FSM SHALL go to DONE; quotient_o and remainder_o SHALL be loaded from the work registers on that same edge.
REQ-019 valid_o SHALL be high for exactly one cycle (DONE), 33 clocks after the sampling edge; DONE SHALL always go to IDLE.
REQ-020 ready_i SHALL be ignored in CALC and DONE; operand changes during CALC SHALL have no effect.
REQ-021 quotient_o and remainder_o SHALL hold their values until the next DONE load.
REQ-022 Divisor 0: the result SHALL be quotient 32'hFFFFFFFF and remainder = dividend; no error flag.
REQ-023 For divisor != 0, the result SHALL equal the truncating quotient and modulo of the unsigned operands.
REQ-024 Back-to-back operation: with ready_i held high, a new operation SHALL start every 34 cycles (IDLE, 32 CALC, DONE).

Reset
REQ-025 Asserting reset SHALL immediately force IDLE and clear valid_o, quotient_o, remainder_o, the work registers, the divisor, and the counter to 0.
REQ-026 Reset asserted during CALC SHALL abort the operation; no DONE SHALL follow until a new start.
REQ-027 On the first rising edge after reset deassertion with ready_i=1, an operation SHALL start.

Configuration
REQ-028 Macro DIVIDER_DEBUG_EN: when defined, debug_state, debug_shift_reg and debug_divisor SHALL reflect internal state; when undefined, the ports SHALL remain present and be tied to 0.

Structure
REQ-029 Package divider_pkg SHALL hold DIV_W, the iteration count (32), and the state enum/encodings.
REQ-030 One combinational sub-module, divider_step, SHALL implement a single REQ-017 iteration and be instantiated once.

Verification
REQ-031 100 / 7 -> quotient 14, remainder 2; valid_o pulses 33 cycles after start.
REQ-032 32'hFFFFFFFF / 1 -> quotient 32'hFFFFFFFF, remainder 0.
REQ-033 32'h80000000 / 32'hFFFFFFFF -> quotient 0, remainder 32'h80000000 (33-bit compare path).
REQ-034 5 / 0 -> quotient 32'hFFFFFFFF, remainder 5.
REQ-035 Random operands changing every half-cycle, ready_i=1 -> every valid_o result matches the operands sampled at its start edge, checked against reference / and %.
REQ-036 Reset pulse at CALC cycle 10 -> outputs 0 and state IDLE immediately; no valid_o until 33 cycles after the next start.
